// File: rtl/oper_result_pipe_if.sv
// Handshake and data bundle for oper_result_pipe: operand side, result side and flags.
// With OPER_PARITY_CHK_EN defined the bundle also carries in_par and par_err.
interface oper_result_pipe_if;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] result;
    logic       carry;
    logic       zero;
    logic       err;
`ifdef OPER_PARITY_CHK_EN
    logic       in_par;
    logic       par_err;

    modport master (
        output in_valid, op, a, b, in_par, out_ready,
        input  in_ready, out_valid, result, carry, zero, err, par_err
    );
    modport slave (
        input  in_valid, op, a, b, in_par, out_ready,
        output in_ready, out_valid, result, carry, zero, err, par_err
    );
`else
    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, carry, zero, err
    );
    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, carry, zero, err
    );
`endif
endinterface

// File: rtl/oper_result_pipe.sv
// Two-stage valid/ready operand-to-result pipe for the 4-bit operator block, with saturating
// transaction/error counters. Define OPER_PARITY_CHK_EN to add the in_par / par_err check.
module oper_result_pipe #(
    parameter int CNT_W = 16,
    parameter int ERR_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr_i,
    oper_result_pipe_if.slave  bus_io,
    output logic [CNT_W-1:0]   op_cnt_o,
    output logic [ERR_W-1:0]   err_cnt_o
);

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_MUL  = 4'd2,
        OP_AND  = 4'd3,
        OP_OR   = 4'd4,
        OP_XOR  = 4'd5,
        OP_NOT  = 4'd6,
        OP_SHR  = 4'd7,
        OP_SHL  = 4'd8,
        OP_CMP  = 4'd9,
        OP_LAND = 4'd10,
        OP_PAR  = 4'd11
    } op_e;

    typedef struct packed {
        logic [7:0] result;
        logic       carry;
        logic       zero;
        logic       err;
    } res_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    logic             s1_valid_q;
    logic [3:0]       s1_op_q;
    logic [3:0]       s1_a_q;
    logic [3:0]       s1_b_q;
    logic             s1_par_bad_q;
    logic             s2_valid_q;
    res_t             res_q;
    res_t             res_d;
    logic [4:0]       sum5;
    logic [4:0]       diff5;
    logic [CNT_W-1:0] op_cnt_q, op_cnt_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

    logic s2_adv;
    logic s1_adv;
    logic in_xfer;
    logic in_illegal;
    logic in_par_bad;

    // Stage 2 frees up when empty or draining; stage 1 when empty or moving into stage 2.
    assign s2_adv     = !s2_valid_q || bus_io.out_ready;
    assign s1_adv     = !s1_valid_q || s2_adv;
    assign in_xfer    = bus_io.in_valid && s1_adv;
    assign in_illegal = (bus_io.op >= 4'd12);

`ifdef OPER_PARITY_CHK_EN
    assign in_par_bad = bus_io.in_par != (^{bus_io.op, bus_io.a, bus_io.b});
`else
    assign in_par_bad = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
        end else if (s1_adv) begin
            s1_valid_q <= bus_io.in_valid;
        end
    end

    // NOTE: stage-1 payload has no reset; it is never observed unless s1_valid_q qualifies it.
    always_ff @(posedge clk) begin
        if (in_xfer) begin
            s1_op_q      <= bus_io.op;
            s1_a_q       <= bus_io.a;
            s1_b_q       <= bus_io.b;
            s1_par_bad_q <= in_par_bad;
        end
    end

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        sum5  = {1'b0, s1_a_q} + {1'b0, s1_b_q};
        diff5 = {1'b0, s1_a_q} - {1'b0, s1_b_q};
        res_d = '0;
        case (s1_op_q)
            OP_ADD: begin
                res_d.result = {3'b000, sum5};
                res_d.carry  = sum5[4];
            end
            OP_SUB: begin
                res_d.result = {3'b000, diff5};
                res_d.carry  = (s1_a_q < s1_b_q);
            end
            OP_MUL:  res_d.result = {4'h0, s1_a_q} * {4'h0, s1_b_q};
            OP_AND:  res_d.result = {4'h0, s1_a_q & s1_b_q};
            OP_OR:   res_d.result = {4'h0, s1_a_q | s1_b_q};
            OP_XOR:  res_d.result = {4'h0, s1_a_q ^ s1_b_q};
            OP_NOT:  res_d.result = {4'h0, ~s1_a_q};
            OP_SHR:  res_d.result = {5'b00000, s1_a_q[3:1]};
            OP_SHL:  res_d.result = {4'h0, s1_a_q[2:0], 1'b0};
            OP_CMP:  res_d.result = {5'b00000, (s1_a_q < s1_b_q), (s1_a_q > s1_b_q),
                                     (s1_a_q == s1_b_q)};
            OP_LAND: res_d.result = {7'b0000000, (s1_a_q != 4'h0) && (s1_b_q != 4'h0)};
            OP_PAR:  res_d.result = {7'b0000000, ^s1_a_q};
            default: res_d.err = 1'b1;
        endcase
        if (s1_par_bad_q) begin
            res_d.result = '0;
            res_d.carry  = 1'b0;
        end
        res_d.zero = (res_d.result == 8'h00);
    end

    // Result and flags only move when stage 2 advances, so they hold while out_ready is low.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_valid_q <= 1'b0;
            res_q      <= '0;
        end else if (s2_adv) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                res_q <= res_d;
            end
        end
    end

`ifdef OPER_PARITY_CHK_EN
    logic par_err_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            par_err_q <= 1'b0;
        end else if (s2_adv && s1_valid_q) begin
            par_err_q <= s1_par_bad_q;
        end
    end

    assign bus_io.par_err = par_err_q;
`endif

    // Clear wins over a same-edge increment; that transfer goes uncounted.
    always_comb begin
        op_cnt_d  = op_cnt_q;
        err_cnt_d = err_cnt_q;
        if (clr_i) begin
            op_cnt_d  = '0;
            err_cnt_d = '0;
        end else if (in_xfer) begin
            if (op_cnt_q != CNT_MAX) begin
                op_cnt_d = op_cnt_q + 1'b1;
            end
            if ((in_illegal || in_par_bad) && (err_cnt_q != ERR_MAX)) begin
                err_cnt_d = err_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_cnt_q  <= '0;
            err_cnt_q <= '0;
        end else begin
            op_cnt_q  <= op_cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign bus_io.in_ready  = s1_adv;
    assign bus_io.out_valid = s2_valid_q;
    assign bus_io.result    = res_q.result;
    assign bus_io.carry     = res_q.carry;
    assign bus_io.zero      = res_q.zero;
    assign bus_io.err       = res_q.err;
    assign op_cnt_o         = op_cnt_q;
    assign err_cnt_o        = err_cnt_q;

endmodule

// File: tb/tb_oper_result_pipe.sv
// Directed self-checking bench for oper_result_pipe: latency, ops, backpressure, errors,
// counter clear, mid-flight reset, and counter saturation on a narrow-counter instance.
module tb_oper_result_pipe;

    typedef struct packed {
        logic [3:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] res;
        logic       c;
        logic       e;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    logic clr;
    logic [15:0] op_cnt;
    logic [7:0]  err_cnt;
    logic [3:0]  sat_op_cnt;
    logic [1:0]  sat_err_cnt;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   stall_sent;
    int   seen;
    vec_t vecs [21];

    oper_result_pipe_if bus ();
    oper_result_pipe_if sat_bus ();

    oper_result_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (clr),
        .bus_io    (bus.slave),
        .op_cnt_o  (op_cnt),
        .err_cnt_o (err_cnt)
    );

    oper_result_pipe #(.CNT_W(4), .ERR_W(2)) dut_sat (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (1'b0),
        .bus_io    (sat_bus.slave),
        .op_cnt_o  (sat_op_cnt),
        .err_cnt_o (sat_err_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.in_valid = 1'b1;
        bus.op       = v.op;
        bus.a        = v.a;
        bus.b        = v.b;
`ifdef OPER_PARITY_CHK_EN
        bus.in_par   = ^{v.op, v.a, v.b};
`endif
    endtask

    task automatic check_out(input string tag, input vec_t v);
        check(tag, {21'd0, bus.result, bus.carry, bus.zero, bus.err},
              {21'd0, v.res, v.c, (v.res == 8'h00), v.e});
`ifdef OPER_PARITY_CHK_EN
        check({tag, "_par"}, {31'd0, bus.par_err}, 32'd0);
`endif
    endtask

    // Streams vecs[first +: n] while out_ready follows rdy_pat (bit per cycle, then 1).
    task automatic run_seq(input int first, input int n, input logic [15:0] rdy_pat);
        int sent = 0;
        int got  = 0;
        int cyc  = 0;
        stall_sent = -1;
        while (got < n && cyc < 200) begin
            if (sent < n) drive(vecs[first + sent]);
            else          bus.in_valid = 1'b0;
            bus.out_ready = (cyc < 16) ? rdy_pat[cyc] : 1'b1;
            @(negedge clk);
            if (bus.out_valid) begin
                check_out($sformatf("seq_v%0d", first + got), vecs[first + got]);
                if (bus.out_ready) got++;
            end
            if (bus.in_valid && !bus.in_ready && stall_sent < 0) stall_sent = sent;
            if (bus.in_valid && bus.in_ready) sent++;
            @(posedge clk); #1;
            cyc++;
        end
        bus.in_valid = 1'b0;
        check("seq_drained", got, n);
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
    endtask

    initial begin
        //            op     a      b      res     c     e
        vecs[0]  = {4'd0,  4'hF, 4'hF, 8'h1E, 1'b1, 1'b0};
        vecs[1]  = {4'd1,  4'h3, 4'h5, 8'h1E, 1'b1, 1'b0};
        vecs[2]  = {4'd9,  4'h8, 4'h8, 8'h01, 1'b0, 1'b0};
        vecs[3]  = {4'd2,  4'hA, 4'hA, 8'h64, 1'b0, 1'b0};
        vecs[4]  = {4'd3,  4'hC, 4'hA, 8'h08, 1'b0, 1'b0};
        vecs[5]  = {4'd4,  4'hC, 4'hA, 8'h0E, 1'b0, 1'b0};
        vecs[6]  = {4'd5,  4'hC, 4'hA, 8'h06, 1'b0, 1'b0};
        vecs[7]  = {4'd6,  4'h5, 4'h0, 8'h0A, 1'b0, 1'b0};
        vecs[8]  = {4'd7,  4'h9, 4'h0, 8'h04, 1'b0, 1'b0};
        vecs[9]  = {4'd8,  4'h9, 4'h0, 8'h02, 1'b0, 1'b0};
        vecs[10] = {4'd9,  4'h3, 4'h7, 8'h04, 1'b0, 1'b0};
        vecs[11] = {4'd9,  4'h7, 4'h3, 8'h02, 1'b0, 1'b0};
        vecs[12] = {4'd10, 4'h4, 4'h0, 8'h00, 1'b0, 1'b0};
        vecs[13] = {4'd10, 4'h4, 4'h1, 8'h01, 1'b0, 1'b0};
        vecs[14] = {4'd11, 4'h7, 4'h0, 8'h01, 1'b0, 1'b0};
        vecs[15] = {4'd0,  4'h0, 4'h0, 8'h00, 1'b0, 1'b0};
        vecs[16] = {4'd1,  4'h5, 4'h3, 8'h02, 1'b0, 1'b0};
        vecs[17] = {4'd13, 4'h6, 4'h2, 8'h00, 1'b0, 1'b1};
        vecs[18] = {4'd15, 4'hF, 4'hF, 8'h00, 1'b0, 1'b1};
        vecs[19] = {4'd2,  4'hF, 4'hF, 8'hE1, 1'b0, 1'b0};
        vecs[20] = {4'd1,  4'h0, 4'h1, 8'h1F, 1'b1, 1'b0};

        rst_n = 1'b0;
        clr   = 1'b0;
        bus.in_valid = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0; bus.out_ready = 1'b0;
        sat_bus.in_valid = 1'b0; sat_bus.op = '0; sat_bus.a = '0; sat_bus.b = '0;
        sat_bus.out_ready = 1'b1;
`ifdef OPER_PARITY_CHK_EN
        bus.in_par = 1'b0;
        sat_bus.in_par = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check("rst_out", {20'd0, bus.out_valid, bus.result, bus.carry, bus.zero, bus.err}, 32'd0);
        check("rst_cnt", {8'd0, op_cnt, err_cnt}, 32'd0);
        check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        rst_n = 1'b1;

        // Latency: accept edge, one registered stage, then result visible.
        drive(vecs[0]);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check("lat_early", {31'd0, bus.out_valid}, 32'd0);
        @(posedge clk); #1;
        check("lat_valid", {31'd0, bus.out_valid}, 32'd1);
        check_out("lat_add", vecs[0]);
        check("lat_op_cnt", {16'd0, op_cnt}, 32'd1);
        @(posedge clk); #1;
        check("lat_drop", {31'd0, bus.out_valid}, 32'd0);

        run_seq(1, 3, 16'hFFFF);
        check("seq3_op_cnt", {16'd0, op_cnt}, 32'd4);

        pulse_clr();
        check("clr_op_cnt", {16'd0, op_cnt}, 32'd0);
        run_seq(4, 6, 16'hFF00);
        check("stall_accepts", stall_sent, 32'd2);
        check("stall_op_cnt", {16'd0, op_cnt}, 32'd6);

        run_seq(10, 7, 16'b1010_0110_1101_0011);
        check("bp_op_cnt", {16'd0, op_cnt}, 32'd13);

        pulse_clr();
        run_seq(17, 2, 16'hFFFF);
        check("ill_err_cnt", {24'd0, err_cnt}, 32'd2);
        check("ill_op_cnt", {16'd0, op_cnt}, 32'd2);

        // Clear coinciding with an accept: counters zero, data still flows.
        drive(vecs[20]);
        bus.out_ready = 1'b1;
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        bus.in_valid = 1'b0;
        check("clr_xfer_cnt", {8'd0, op_cnt, err_cnt}, 32'd0);
        @(posedge clk); #1;
        check("clr_xfer_valid", {31'd0, bus.out_valid}, 32'd1);
        check_out("clr_xfer_data", vecs[20]);
        @(posedge clk); #1;

        // Reset with both stages full.
        bus.out_ready = 1'b0;
        drive(vecs[19]);
        @(posedge clk); #1;
        drive(vecs[3]);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check("pre_rst_full", {31'd0, bus.out_valid}, 32'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("mid_rst_out", {23'd0, bus.out_valid, bus.result}, 32'd0);
        check("mid_rst_cnt", {16'd0, op_cnt}, 32'd0);
        bus.out_ready = 1'b1;
        seen = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (bus.out_valid) seen++;
        end
        check("mid_rst_no_stale", seen, 32'd0);

        // Saturation on the CNT_W=4 / ERR_W=2 instance with illegal ops.
        sat_bus.op = 4'hE;
        sat_bus.in_valid = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            @(posedge clk); #1;
            if (k == 3)  check("sat_err_reach", {30'd0, sat_err_cnt}, 32'd3);
            if (k == 4)  check("sat_err_hold", {30'd0, sat_err_cnt}, 32'd3);
            if (k == 15) check("sat_op_reach", {28'd0, sat_op_cnt}, 32'hF);
        end
        sat_bus.in_valid = 1'b0;
        check("sat_op_hold", {28'd0, sat_op_cnt}, 32'hF);
        check("sat_err_final", {30'd0, sat_err_cnt}, 32'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/oper_result_pipe.md
Name: oper_result_pipe

Overview:
- Registered, handshaked operand-to-result stage for the 4-bit operator block.
- Accepts one {op, a, b} transaction per cycle and computes the one selected result.
- Delivers the result with status flags through a 2-stage valid/ready pipeline.
- Maintains saturating transaction and error counters for the downstream control logic.

Parameters:
CNT_W, 16, width of accepted-transaction counter op_cnt
ERR_W, 8, width of illegal-opcode counter err_cnt

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
in_valid  input  1  upstream transaction valid
in_ready  output  1  stage can accept a transaction this cycle
op  input  4  operation select, encoding in Behaviour
a  input  4  operand A
b  input  4  operand B
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
result  output  8  selected result, zero-extended
carry  output  1  ADD carry-out / SUB borrow, 0 for other ops
zero  output  1  result == 8'h00
err  output  1  op was illegal
clr  input  1  synchronous counter clear pulse
op_cnt  output  CNT_W  accepted transactions, saturating
err_cnt  output  ERR_W  accepted illegal ops, saturating

Behaviour:
- Clock and reset: single clock clk; reset rst_n is synchronous and active-low.
- Reset (rst_n=0 at a clk edge):
  - s1_valid, s2_valid, out_valid = 0.
  - result = 0, carry = 0, zero = 0, err = 0.
  - op_cnt = 0, err_cnt = 0.
  - Reset mid-transfer discards all in-flight data with no partial output.
- Handshake:
  - Transfer occurs when valid && ready on the same edge.
  - Upstream data must stay stable while in_valid=1 and in_ready=0.
  - out_valid, once high, stays high with result/flags stable until out_ready=1.
- Pipeline:
  - Stage 1 registers {op, a, b}.
  - Stage 2 registers the computed result and flags, and drives the outputs.
  - s2 advances when !s2_valid || out_ready.
  - s1 advances when !s1_valid || s2 advance.
  - in_ready = !s1_valid || s2 advance. This is combinational from out_ready; no other combinational in→out paths.
  - Latency: 2 cycles from the accepting edge to out_valid when out_ready=1.
  - Throughput: 1 per cycle. No bubbles inserted; no data dropped or duplicated under any backpressure pattern.
- Operation encoding (all operands unsigned; result zero-extended to 8 bits):
  - 0 ADD: {3'b0, a+b[4:0]}; carry = sum bit 4.
  - 1 SUB: {3'b0, (a-b) mod 32}; carry = 1 when a<b.
  - 2 MUL: a*b, 8 bits.
  - 3 AND: a&b.
  - 4 OR: a|b.
  - 5 XOR: a^b.
  - 6 NOT: ~a.
  - 7 SHR: a>>1.
  - 8 SHL: (a<<1) truncated to 4 bits.
  - 9 CMP: {5'b0, lt, gt, eq}.
  - 10 LAND: {7'b0, (a!=0)&&(b!=0)}.
  - 11 PAR: {7'b0, ^a}.
  - 12–15 illegal: result = 0, err = 1, zero = 1.
- Flags:
  - zero is computed on the final 8-bit result.
  - carry = 0 for every op other than ADD and SUB.
- Counters:
  - op_cnt increments on each input-side transfer.
  - err_cnt increments on each input-side transfer with an illegal op.
  - Both hold at all-ones (no wrap).
  - clr=1 sets both counters to 0 on that edge. clr has priority over a simultaneous increment, and that transfer is not counted.
  - clr does not affect pipeline data.

Optional Feature:
- Macro: OPER_PARITY_CHK_EN.
- When defined:
  - Extra input in_par (1 bit) = expected ^{op,a,b}, sampled with the transaction.
  - Extra output par_err (1 bit) travels aligned with result; reset value 0.
  - par_err = 1 when the parity mismatches. On a mismatch, result is forced to 0 and the transaction is also counted in err_cnt.
- When undefined: neither port exists, and behaviour is exactly as above.

Test Plan:
- Reset then ADD a=4'hF, b=4'hF, out_ready=1 → 2 cycles after accept: result=8'h1E, carry=1, zero=0, op_cnt=1.
- SUB a=4'h3, b=4'h5 → result=8'h1E, carry=1. Then CMP a=4'h8, b=4'h8 → result=8'h01. Then MUL a=4'hA, b=4'hA → result=8'h64.
- Stream 6 back-to-back ops with out_ready held 0 → in_ready falls after 2 accepts; release out_ready → all 6 results emerge in order, none lost or duplicated, op_cnt=6.
- op=4'hD, then op=4'hF → err=1, result=0, zero=1 on each; err_cnt=2. Assert clr on the same edge as a third accept → both counters read 0.
- Drive rst_n=0 for one edge while 2 transactions are in flight → out_valid=0 next cycle, and no stale result ever appears.
- Force op_cnt near saturation (CNT_W=4 build, 17 accepts) → op_cnt holds at 4'hF.
